// File: rtl/bms_contactor_seq_if.sv
// Contactor sequencer bus: protection state, host and plant inputs, relay commands and status.
interface bms_contactor_seq_if;
    logic [3:0] state_1hot;
    logic       close_req;
    logic       fault_clr;
    logic       vmatch;
    logic       aux_neg;
    logic       aux_pos;
    logic       neg_cmd;
    logic       pre_cmd;
    logic       pos_cmd;
    logic       ready;
    logic       busy;
    logic       seq_fault;
    logic [2:0] fault_code;
    logic [1:0] retry_cnt;

    modport master (
        output state_1hot, close_req, fault_clr, vmatch, aux_neg, aux_pos,
        input  neg_cmd, pre_cmd, pos_cmd, ready, busy, seq_fault, fault_code, retry_cnt
    );

    modport slave (
        input  state_1hot, close_req, fault_clr, vmatch, aux_neg, aux_pos,
        output neg_cmd, pre_cmd, pos_cmd, ready, busy, seq_fault, fault_code, retry_cnt
    );
endinterface

// File: rtl/bms_contactor_seq.sv
// Pack contactor sequencer: neg close, precharge, pos close, orderly/forced open, retry then lockout.
// Latency: one edge from qualifying input to new state and commands; no backpressure, all outputs registered.
module bms_contactor_seq #(
    parameter int PRECHG_MIN = 50,
    parameter int PRECHG_TMO = 200,
    parameter int FB_TMO     = 10,
    parameter int OPEN_DLY   = 4,
    parameter int WELD_CYC   = 3,
    parameter int RETRY_MAX  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bms_contactor_seq_if.slave   bus
);
    localparam int CW = $clog2(PRECHG_TMO + 1);
    localparam int WW = $clog2(WELD_CYC + 1);
    localparam logic [CW-1:0] FB_LAST   = CW'(FB_TMO - 1);
    localparam logic [CW-1:0] PRE_READY = CW'(PRECHG_MIN - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRECHG_TMO - 1);
    localparam logic [CW-1:0] OPEN_END  = CW'(OPEN_DLY);
    localparam logic [WW-1:0] WELD_LAST = WW'(WELD_CYC - 1);
    localparam logic [1:0]    RETRY_LIM = 2'(RETRY_MAX);

    localparam logic [2:0] FC_NONE = 3'd0, FC_NEG = 3'd1, FC_PRE = 3'd2,
                           FC_POS = 3'd3, FC_DROP = 3'd4, FC_WELD = 3'd5;

    typedef enum logic [2:0] {
        S_OPEN, S_CLOSE_NEG, S_PRECHG, S_CLOSE_POS, S_CLOSED, S_OPENING, S_LOCKOUT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   weld_q, weld_d;
    logic [2:0]      fault_code_q, fault_code_d;
    logic [1:0]      retry_cnt_q, retry_cnt_d;
    logic            neg_q, pre_q, pos_q, ready_q, busy_q, seq_fault_q;
    logic            retry_inc;

    logic is_norm, is_warn, is_fault, shutdown, allow, aux_any, sequencing;
    assign is_norm    = (bus.state_1hot == 4'b0001);
    assign is_warn    = (bus.state_1hot == 4'b0010);
    assign is_fault   = (bus.state_1hot == 4'b0100);
    // Anything that is not a legal one-hot code is handled like SHUTDOWN.
    assign shutdown   = !(is_norm || is_warn || is_fault);
    assign allow      = is_norm || is_warn;
    assign aux_any    = bus.aux_neg || bus.aux_pos;
    assign sequencing = (state_q == S_CLOSE_NEG) || (state_q == S_PRECHG) || (state_q == S_CLOSE_POS);

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        retry_cnt_d  = retry_cnt_q;
        weld_d       = '0;
        retry_inc    = 1'b0;
        case (state_q)
            S_OPEN: begin
                if (aux_any) weld_d = (weld_q == WELD_LAST) ? weld_q : weld_q + 1'b1;
                if (aux_any && weld_q == WELD_LAST) begin
                    state_d      = S_LOCKOUT;
                    fault_code_d = FC_WELD;
                end else if (bus.close_req && allow && !aux_any) begin
                    state_d = S_CLOSE_NEG;
                end
            end
            S_CLOSE_NEG: begin
                if (bus.aux_neg) state_d = S_PRECHG;
                else if (cnt_q == FB_LAST) begin
                    state_d = S_OPENING; fault_code_d = FC_NEG; retry_inc = 1'b1;
                end
            end
            S_PRECHG: begin
                if (cnt_q >= PRE_READY && bus.vmatch) state_d = S_CLOSE_POS;
                else if (cnt_q == PRE_LAST) begin
                    state_d = S_OPENING; fault_code_d = FC_PRE; retry_inc = 1'b1;
                end
            end
            S_CLOSE_POS: begin
                if (bus.aux_pos) begin
                    state_d = S_CLOSED; fault_code_d = FC_NONE; retry_cnt_d = 2'd0;
                end else if (cnt_q == FB_LAST) begin
                    state_d = S_OPENING; fault_code_d = FC_POS; retry_inc = 1'b1;
                end
            end
            S_CLOSED: begin
                if (!bus.close_req) state_d = S_OPENING;
                else if (!bus.aux_neg || !bus.aux_pos) begin
                    state_d = S_OPENING; fault_code_d = FC_DROP;
                end
            end
            S_OPENING: begin
                if (cnt_q == OPEN_END)
                    state_d = (fault_code_q == FC_DROP || retry_cnt_q == RETRY_LIM) ? S_LOCKOUT : S_OPEN;
            end
            S_LOCKOUT: begin
                if (bus.fault_clr && is_norm) begin
                    state_d = S_OPEN; fault_code_d = FC_NONE; retry_cnt_d = 2'd0;
                end
            end
            default: state_d = S_OPEN;
        endcase

        if (retry_inc && retry_cnt_q != 2'd3) retry_cnt_d = retry_cnt_q + 2'd1;

        // Overrides undo any fault/retry bookkeeping the normal transition did.
        if (state_q != S_LOCKOUT) begin
            if (shutdown) begin
                state_d = S_OPEN; fault_code_d = fault_code_q; retry_cnt_d = retry_cnt_q;
            end else if ((is_fault && (sequencing || state_q == S_CLOSED)) ||
                         (!bus.close_req && sequencing)) begin
                state_d = S_OPENING; fault_code_d = fault_code_q; retry_cnt_d = retry_cnt_q;
            end
        end

        cnt_d = (state_d != state_q) ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OPEN;
            cnt_q        <= '0;
            weld_q       <= '0;
            fault_code_q <= FC_NONE;
            retry_cnt_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            weld_q       <= weld_d;
            fault_code_q <= fault_code_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end

    // Commands are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0; pre_q <= 1'b0; pos_q <= 1'b0;
            ready_q <= 1'b0; busy_q <= 1'b0; seq_fault_q <= 1'b0;
        end else begin
            neg_q       <= (state_d == S_CLOSE_NEG) || (state_d == S_PRECHG) || (state_d == S_CLOSE_POS) ||
                           (state_d == S_CLOSED) || (state_d == S_OPENING && cnt_d < OPEN_END);
            pre_q       <= (state_d == S_PRECHG) || (state_d == S_CLOSE_POS);
            pos_q       <= (state_d == S_CLOSE_POS) || (state_d == S_CLOSED);
            ready_q     <= (state_d == S_CLOSED);
            busy_q      <= (state_d == S_CLOSE_NEG) || (state_d == S_PRECHG) ||
                           (state_d == S_CLOSE_POS) || (state_d == S_OPENING);
            seq_fault_q <= (state_d == S_LOCKOUT);
        end
    end

    assign bus.neg_cmd    = neg_q;
    assign bus.pre_cmd    = pre_q;
    assign bus.pos_cmd    = pos_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.seq_fault  = seq_fault_q;
    assign bus.fault_code = fault_code_q;
    assign bus.retry_cnt  = retry_cnt_q;
endmodule

// File: tb/tb_bms_contactor_seq.sv
// Directed bench for bms_contactor_seq with a contactor plant whose aux contacts follow commands by two edges.
module tb_bms_contactor_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    // Plant overrides for stuck/welded contacts.
    logic neg_force = 1'b0, neg_fval = 1'b0;
    logic pos_force = 1'b0, pos_fval = 1'b0;

    localparam logic [3:0] NORM = 4'b0001, WARN = 4'b0010, FLT = 4'b0100, SHDN = 4'b1000;

    bms_contactor_seq_if bus ();

    bms_contactor_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        logic [1:0] npipe, ppipe;
        npipe = 2'b00; ppipe = 2'b00;
        bus.aux_neg = 1'b0; bus.aux_pos = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            npipe = {npipe[0], bus.neg_cmd};
            ppipe = {ppipe[0], bus.pos_cmd};
            bus.aux_neg = neg_force ? neg_fval : npipe[1];
            bus.aux_pos = pos_force ? pos_fval : ppipe[1];
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pick(input int w);
        case (w)
            0: return int'(bus.neg_cmd);
            1: return int'(bus.pre_cmd);
            2: return int'(bus.pos_cmd);
            3: return int'(bus.ready);
            4: return int'(bus.busy);
            5: return int'(bus.seq_fault);
            6: return int'(bus.fault_code);
            default: return int'(bus.retry_cnt);
        endcase
    endfunction

    // Returns the number of falling edges until the selected output equals val, or -1 on timeout.
    task automatic wait_for(input string tag, input int w, input int val, input int max, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (pick(w) == val) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles waiting for %0d", tag, max, val);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_neg"}, int'(bus.neg_cmd), 0);
        chk({tag, "_pre"}, int'(bus.pre_cmd), 0);
        chk({tag, "_pos"}, int'(bus.pos_cmd), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic clear_lockout();
        bus.close_req = 1'b0;
        bus.state_1hot = NORM;
        step(4);
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
    endtask

    initial begin
        bus.state_1hot = NORM;
        bus.close_req  = 1'b0;
        bus.fault_clr  = 1'b0;
        bus.vmatch     = 1'b0;
        step(3);
        chk_idle("rst");
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_seq_fault", int'(bus.seq_fault), 0);
        chk("rst_code", int'(bus.fault_code), 0);
        chk("rst_retry", int'(bus.retry_cnt), 0);
        rst_n = 1'b1;
        step(2);

        // Nominal close, vmatch arriving at PRECHG cycle 30, then orderly open.
        bus.close_req = 1'b1;
        wait_for("nom_neg", 0, 1, 5, n);
        chk("nom_neg_lat", n, 1);
        wait_for("nom_pre", 1, 1, 20, n);
        step(30);
        bus.vmatch = 1'b1;
        wait_for("nom_pos", 2, 1, 100, n);
        chk("nom_pos_at_50", 30 + n, 50);
        chk("nom_pre_in_cpos", int'(bus.pre_cmd), 1);
        wait_for("nom_ready", 3, 1, 10, n);
        chk("nom_code", int'(bus.fault_code), 0);
        chk("nom_busy", int'(bus.busy), 0);
        chk("nom_pre_off", int'(bus.pre_cmd), 0);
        bus.close_req = 1'b0;
        step(1);
        chk("open_pos", int'(bus.pos_cmd), 0);
        chk("open_neg_held", int'(bus.neg_cmd), 1);
        chk("open_ready", int'(bus.ready), 0);
        wait_for("open_neg", 0, 0, 10, n);
        chk("open_dly", n, 4);
        step(1);
        chk("open_busy", int'(bus.busy), 0);
        step(4);

        // Precharge timeout twice, then lockout.
        bus.vmatch = 1'b0;
        bus.close_req = 1'b1;
        wait_for("tmo_pre1", 1, 1, 20, n);
        wait_for("tmo_code", 6, 2, 250, n);
        chk("tmo_len1", n, 200);
        chk("tmo_retry1", int'(bus.retry_cnt), 1);
        chk("tmo_busy", int'(bus.busy), 1);
        wait_for("tmo_pre2", 1, 1, 30, n);
        wait_for("tmo_retry2", 7, 2, 250, n);
        chk("tmo_len2", n, 200);
        wait_for("tmo_lock", 5, 1, 20, n);
        chk("tmo_lock_code", int'(bus.fault_code), 2);
        chk("tmo_lock_neg", int'(bus.neg_cmd), 0);
        bus.close_req = 1'b0;
        bus.state_1hot = WARN;
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        step(1);
        chk("clr_warn_lock", int'(bus.seq_fault), 1);
        chk("clr_warn_retry", int'(bus.retry_cnt), 2);
        bus.state_1hot = NORM;
        bus.fault_clr = 1'b1;
        step(1);
        bus.fault_clr = 1'b0;
        chk("clr_norm_lock", int'(bus.seq_fault), 0);
        chk("clr_norm_retry", int'(bus.retry_cnt), 0);
        chk("clr_norm_code", int'(bus.fault_code), 0);

        // Positive feedback stuck open, then success on retry.
        pos_force = 1'b1; pos_fval = 1'b0;
        bus.vmatch = 1'b1;
        bus.close_req = 1'b1;
        wait_for("fb_pos", 2, 1, 100, n);
        wait_for("fb_code", 6, 3, 30, n);
        chk("fb_len", n, 10);
        chk("fb_retry", int'(bus.retry_cnt), 1);
        chk("fb_pos_off", int'(bus.pos_cmd), 0);
        pos_force = 1'b0;
        wait_for("fb_ready", 3, 1, 200, n);
        chk("fb_retry_clr", int'(bus.retry_cnt), 0);
        chk("fb_code_clr", int'(bus.fault_code), 0);

        // Positive aux drops while closed: non-retryable.
        pos_force = 1'b1; pos_fval = 1'b0;
        wait_for("drop_open", 3, 0, 10, n);
        chk("drop_code", int'(bus.fault_code), 4);
        chk("drop_busy", int'(bus.busy), 1);
        wait_for("drop_lock", 5, 1, 10, n);
        chk("drop_lock_retry", int'(bus.retry_cnt), 0);
        pos_force = 1'b0;
        clear_lockout();

        // Welded negative contact while open.
        step(4);
        neg_force = 1'b1; neg_fval = 1'b1;
        wait_for("weld_lock", 5, 1, 10, n);
        chk("weld_code", int'(bus.fault_code), 5);
        neg_force = 1'b0;
        clear_lockout();
        chk("weld_clr", int'(bus.seq_fault), 0);

        // SHUTDOWN mid-precharge.
        step(4);
        bus.vmatch = 1'b0;
        bus.close_req = 1'b1;
        wait_for("sd_pre", 1, 1, 20, n);
        step(10);
        bus.state_1hot = SHDN;
        step(1);
        chk_idle("sd");
        chk("sd_code", int'(bus.fault_code), 0);

        // FAULT while closed gives an orderly open.
        bus.state_1hot = NORM;
        bus.vmatch = 1'b1;
        wait_for("flt_ready", 3, 1, 200, n);
        bus.state_1hot = FLT;
        step(1);
        chk("flt_pos", int'(bus.pos_cmd), 0);
        chk("flt_neg", int'(bus.neg_cmd), 1);
        chk("flt_code", int'(bus.fault_code), 0);
        wait_for("flt_neg_off", 0, 0, 10, n);
        chk("flt_dly", n, 4);

        // Illegal protection state acts as SHUTDOWN.
        bus.state_1hot = NORM;
        wait_for("ill_pre", 1, 1, 40, n);
        bus.state_1hot = 4'b0011;
        step(1);
        chk_idle("ill");

        // Asynchronous reset while closed.
        bus.state_1hot = NORM;
        wait_for("ar_ready", 3, 1, 200, n);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_ready", int'(bus.ready), 0);
        chk("ar_neg", int'(bus.neg_cmd), 0);
        chk("ar_pos", int'(bus.pos_cmd), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bms_contactor_seq.md
# bms_contactor_seq

Pack contactor sequencer driven by the protection FSM state. It closes the negative contactor, precharges the bus through the precharge relay, then closes the positive contactor, using auxiliary-contact feedback and a bus-voltage-match flag at each step. It performs an orderly open on request or on FAULT and a forced open on SHUTDOWN. Bounded auto-retry is followed by a latched lockout. It sits between `bms_fsm` (`state_1hot`) and the relay drivers.

## Interface
- `PRECHG_MIN`, 50: minimum cycles in PRECHG before positive close is allowed.
- `PRECHG_TMO`, 200: PRECHG cycle limit without `vmatch`; reaching it is a timeout fault. Must exceed `PRECHG_MIN`.
- `FB_TMO`, 10: cycles allowed for aux feedback after a close command.
- `OPEN_DLY`, 4: cycles negative stays closed after positive/precharge open.
- `WELD_CYC`, 3: consecutive cycles of aux=1 while commanded open that declare a weld.
- `RETRY_MAX`, 2: retryable faults allowed before lockout (1..3).
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `state_1hot` in 4: {SHUTDOWN, FAULT, WARN, NORM} from `bms_fsm`.
- `close_req` in 1: host level request to connect the pack.
- `fault_clr` in 1: single-cycle lockout clear.
- `vmatch` in 1: bus voltage within precharge window (synchronous).
- `aux_neg`, `aux_pos` in 1 each: contactor aux feedback (1 = closed, synchronous).
- `neg_cmd`, `pre_cmd`, `pos_cmd` out 1 each: relay commands (1 = close).
- `ready` out 1: pack connected (state CLOSED).
- `busy` out 1: in CLOSE_NEG, PRECHG, CLOSE_POS or OPENING.
- `seq_fault` out 1: in LOCKOUT.
- `fault_code` out 3: 0 none, 1 NEG_FB, 2 PRE_TMO, 3 POS_FB, 4 DROP, 5 WELD.
- `retry_cnt` out 2: retryable faults since the last success or clear.

## Operation
- States: OPEN, CLOSE_NEG, PRECHG, CLOSE_POS, CLOSED, OPENING, LOCKOUT.
- Dwell counter `cnt` clears on every state change, increments each cycle and saturates. Width is `$clog2(PRECHG_TMO+1)`.
- "allow" = `state_1hot` is NORM or WARN. A non-one-hot `state_1hot` is treated as SHUTDOWN.
- Commands per state (all other commands 0):
  - CLOSE_NEG: `neg_cmd`.
  - PRECHG: `neg_cmd` + `pre_cmd`.
  - CLOSE_POS: all three.
  - CLOSED: `neg_cmd` + `pos_cmd`.
  - OPENING: `neg_cmd` only, while `cnt < OPEN_DLY`.
  - OPEN and LOCKOUT: none.
- OPEN:
  - `close_req & allow & !aux_neg & !aux_pos` → CLOSE_NEG.
  - `aux_neg|aux_pos` for `WELD_CYC` consecutive cycles → LOCKOUT, code 5 (non-retryable).
- CLOSE_NEG:
  - `aux_neg` → PRECHG.
  - `cnt == FB_TMO-1` without `aux_neg` → OPENING, code 1.
- PRECHG:
  - `cnt >= PRECHG_MIN-1 & vmatch` → CLOSE_POS.
  - `cnt == PRECHG_TMO-1` without that condition → OPENING, code 2.
- CLOSE_POS:
  - `aux_pos` → CLOSED; `retry_cnt` clears and `fault_code` returns to 0.
  - `cnt == FB_TMO-1` without `aux_pos` → OPENING, code 3.
- CLOSED:
  - `!close_req` → OPENING, no fault.
  - `!aux_neg | !aux_pos` → OPENING, code 4 (non-retryable).
- Retryable faults (codes 1–3) increment `retry_cnt` on entry to OPENING.
- OPENING, at `cnt == OPEN_DLY`:
  - → LOCKOUT if a non-retryable fault is pending or `retry_cnt == RETRY_MAX`.
  - otherwise → OPEN. Auto-retry happens naturally if `close_req` is still high.
- LOCKOUT: `fault_clr & state_1hot == NORM` → OPEN; clears `fault_code` and `retry_cnt`.
- Override priority (highest first), applied from any state except LOCKOUT:
  - SHUTDOWN (or illegal): next state OPEN with all commands 0 in the same edge. No fault code, no retry increment.
  - FAULT: CLOSE_NEG, PRECHG, CLOSE_POS or CLOSED → OPENING, no fault code.
  - `close_req` dropping during CLOSE_NEG/PRECHG/CLOSE_POS → OPENING.
- SHUTDOWN during LOCKOUT: stay in LOCKOUT.

## Timing
- All outputs are registered and reflect the current state, with no combinational input-to-output paths.
- Reset (async): state OPEN, all commands 0, `ready`/`busy`/`seq_fault` = 0, `fault_code` = 0, `retry_cnt` = 0, `cnt` = 0.
- State-entry latency: a qualifying input sampled at edge N gives the new state and its commands after edge N.
- Nominal close, aux responding the cycle after command, `vmatch` already 1:
  - `neg_cmd` rises at edge 1.
  - `pre_cmd` rises at edge 2.
  - `pos_cmd` rises at edge 2+`PRECHG_MIN`.
  - `ready` rises one edge after `aux_pos` is seen.
- Orderly open: `pos_cmd` and `pre_cmd` drop at edge 1; `neg_cmd` drops `OPEN_DLY` edges later; OPEN follows on the next edge.
- SHUTDOWN: all commands 0 one edge after SHUTDOWN is sampled.
- Simultaneous events: SHUTDOWN > FAULT > fault timeout > normal transition. When a feedback arrival and its timeout occur in the same cycle, the feedback wins.
- `fault_clr` sampled outside LOCKOUT is ignored.

## Test plan
- Nominal close: NORM, `close_req`=1, aux follows command after 2 cycles, `vmatch`=1 from PRECHG cycle 30 → `pos_cmd` at PRECHG cycle 50, `ready`=1, `fault_code`=0; drop `close_req` → `pos_cmd` 0, `neg_cmd` 0 four cycles later.
- Precharge timeout with retry: `vmatch`=0 throughout → code 2 after 200 PRECHG cycles, `retry_cnt` 1 then 2 across two attempts, then LOCKOUT with `seq_fault`=1. `fault_clr` while WARN is ignored; while NORM → OPEN with `retry_cnt`=0.
- Feedback failure: `aux_pos` stuck 0 → code 3 after 10 CLOSE_POS cycles → OPENING; then a success on retry clears `retry_cnt`.
- Weld/drop: `aux_neg`=1 for 3 cycles in OPEN → LOCKOUT code 5. `aux_pos` drops in CLOSED → OPENING then LOCKOUT code 4 with no retry.
- Overrides:
  - SHUTDOWN mid-PRECHG → all commands 0 next edge, state OPEN, code 0.
  - FAULT in CLOSED → orderly open.
  - `state_1hot`=4'b0011 treated as SHUTDOWN.
- Async reset asserted during CLOSED → all outputs 0 immediately, without waiting for a clock edge.
